core_seq_ctrl: RTL

- Single-tile sequencer for the PE-array core; drives the 34-bit core instruction word, `xw_mode` and `pmem_mode`.
- One tile runs in this order:
  - Fetch `row` weight words from weight SRAM into L0, then load them into the PE array.
  - Flush the array.
  - Stream `nij` activation words from activation SRAM through L0 and execute.
  - Drain OFIFO results into psum SRAM.
- Started by a one-cycle `start` pulse; completion is signalled by a one-cycle `done` pulse.

---
 rtl/core_ctrl_pkg.sv | 35 +++
 rtl/core_seq_ctrl_addr_stepper.sv | 46 ++++
 rtl/core_seq_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the PE-array core sequencer: instruction field
// positions, the idle instruction word and the sequencer state encoding.
package core_ctrl_pkg;

  localparam int INST_W        = 34;
  localparam int INST_ACC      = 33;
  localparam int INST_P_CEN    = 32;
  localparam int INST_P_WEN    = 31;
  localparam int INST_P_ADDR   = 20;
  localparam int INST_X_CEN    = 19;
  localparam int INST_X_WEN    = 18;
  localparam int INST_X_ADDR   = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXECUTE  = 1;
  localparam int INST_LOAD     = 0;

  // Both SRAMs deselected and write-protected; every other field zero.
  localparam logic [INST_W-1:0] IDLE_INST = (34'd1 << INST_P_CEN) | (34'd1 << INST_P_WEN) |
                                            (34'd1 << INST_X_CEN) | (34'd1 << INST_X_WEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_FETCH,
    ST_W_LOAD,
    ST_W_FLUSH,
    ST_X_EXEC,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/core_seq_ctrl_addr_stepper.sv
// addr_stepper: loadable SRAM address generator. Presents base+index for one
// cycle per step (zero otherwise) and flags when 'limit' addresses were issued.
module addr_stepper #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_limit,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_limit;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base  <= '0;
      r_limit <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
    end else begin
      if (i_load) begin
        r_base  <= i_base;
        r_limit <= i_limit;
      end
      // A load may coincide with the first step so the first address is not delayed.
      if (i_step) begin
        r_addr <= i_load ? i_base : r_base + r_idx;
        r_idx  <= i_load ? ADDR_W'(1) : r_idx + ADDR_W'(1);
      end else begin
        r_addr <= '0;
        if (i_load) r_idx <= '0;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_idx == r_limit);

endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: single-tile sequencer for the PE-array core. Every output is
// registered from the next-state decode so it lines up with the state it belongs to.
module core_seq_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int row       = 8,
  parameter int col       = 8,
  parameter int ADDR_W    = 11,
  parameter int FLUSH_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic [ADDR_W-1:0] nij,
  input  logic              acc_en,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              xw_mode,
  output logic              pmem_mode,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ROW_A      = ADDR_W'(row);
  localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(col - 1);
  localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'(FLUSH_CYC - 1);

  state_e            r_state;
  state_e            w_state_n;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_n;
  logic [ADDR_W-1:0] r_x_base;
  logic [ADDR_W-1:0] r_nij;
  logic              r_acc;
  logic [ADDR_W-1:0] r_rd_cnt;

  logic              r_inst_acc;
  logic              r_x_cen;
  logic              r_p_cen;
  logic [6:0]        r_ctrl;
  logic              r_xw;
  logic              r_busy;
  logic              r_done;

  logic              w_latch;
  logic              w_x_load;
  logic [ADDR_W-1:0] w_x_base;
  logic [ADDR_W-1:0] w_x_limit;
  logic              w_x_step;
  logic              w_x_last;
  logic [ADDR_W-1:0] w_x_addr;
  logic              w_p_last;
  logic [ADDR_W-1:0] w_p_addr;
  logic [6:0]        w_ctrl_n;
  logic              w_xw_n;
  logic              w_busy_n;
  logic              w_done_n;
  logic              w_acc_n;

  // NOTE: every signal written here gets a default first, otherwise a path that
  // skips the assignment makes synthesis infer a latch.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + ADDR_W'(1);
    w_latch   = 1'b0;
    w_x_load  = 1'b0;
    w_x_base  = w_base;
    w_x_limit = ROW_A;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_n = '0;
        if (start && (nij != '0)) begin
          w_state_n = ST_W_FETCH;
          w_latch   = 1'b1;
          w_x_load  = 1'b1;
        end
      end
      ST_W_FETCH: if (r_cnt == ROW_A) begin
        w_state_n = ST_W_LOAD;
        w_cnt_n   = '0;
      end
      ST_W_LOAD: if (r_cnt == COL_LAST) begin
        w_state_n = ST_W_FLUSH;
        w_cnt_n   = '0;
      end
      ST_W_FLUSH: if (r_cnt == FLUSH_LAST) begin
        w_state_n = ST_X_EXEC;
        w_cnt_n   = '0;
        w_x_load  = 1'b1;
        w_x_base  = r_x_base;
        w_x_limit = r_nij;
      end
      ST_X_EXEC: if (r_cnt == r_nij) begin
        w_state_n = ST_DRAIN;
        w_cnt_n   = '0;
      end
      ST_DRAIN: begin
        w_cnt_n = r_cnt;
        if (w_p_last) w_state_n = ST_DONE;
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Output decode for the cycle the next state describes.
  always_comb begin
    w_ctrl_n = '0;
    w_xw_n   = 1'b0;
    unique case (w_state_n)
      ST_W_FETCH: begin
        w_xw_n               = 1'b1;
        w_ctrl_n[INST_L0_WR] = (w_cnt_n != '0);
      end
      ST_W_LOAD: begin
        w_ctrl_n[INST_L0_RD] = 1'b1;
        w_ctrl_n[INST_LOAD]  = 1'b1;
      end
      ST_X_EXEC: begin
        w_ctrl_n[INST_L0_WR]   = (w_cnt_n != '0);
        w_ctrl_n[INST_L0_RD]   = (w_cnt_n != '0);
        w_ctrl_n[INST_EXECUTE] = (w_cnt_n != '0);
      end
      ST_DRAIN: w_ctrl_n[INST_OFIFO_RD] = (r_state == ST_DRAIN) && ofifo_valid &&
                                          (r_rd_cnt < r_nij);
      default: begin
        w_ctrl_n[INST_IFIFO_WR] = 1'b0;
        w_ctrl_n[INST_IFIFO_RD] = 1'b0;
      end
    endcase
    w_x_step = w_x_load || (((w_state_n == ST_W_FETCH) || (w_state_n == ST_X_EXEC)) && !w_x_last);
    w_busy_n = (w_state_n != ST_IDLE) && (w_state_n != ST_DONE);
    w_done_n = (w_state_n == ST_DONE) || ((r_state == ST_IDLE) && start && (nij == '0));
    w_acc_n  = w_busy_n && ((r_state == ST_IDLE) ? acc_en : r_acc);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_x_base   <= '0;
      r_nij      <= '0;
      r_acc      <= 1'b0;
      r_rd_cnt   <= '0;
      r_inst_acc <= 1'b0;
      r_x_cen    <= 1'b1;
      r_p_cen    <= 1'b1;
      r_ctrl     <= '0;
      r_xw       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_latch) begin
        r_x_base <= x_base;
        r_nij    <= nij;
        r_acc    <= acc_en;
      end
      if (w_latch) r_rd_cnt <= '0;
      else if (w_ctrl_n[INST_OFIFO_RD]) r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
      r_inst_acc <= w_acc_n;
      r_x_cen    <= ~w_x_step;
      // Each OFIFO read is written to psum SRAM in the following cycle.
      r_p_cen    <= ~r_ctrl[INST_OFIFO_RD];
      r_ctrl     <= w_ctrl_n;
      r_xw       <= w_xw_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
    end
  end

  addr_stepper #(.ADDR_W(ADDR_W)) u_x_addr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_x_load),
    .i_base  (w_x_base),
    .i_limit (w_x_limit),
    .i_step  (w_x_step),
    .o_addr  (w_x_addr),
    .o_last  (w_x_last)
  );

  addr_stepper #(.ADDR_W(ADDR_W)) u_p_addr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_latch),
    .i_base  (p_base),
    .i_limit (nij),
    .i_step  (r_ctrl[INST_OFIFO_RD]),
    .o_addr  (w_p_addr),
    .o_last  (w_p_last)
  );

  always_comb begin
    inst                              = IDLE_INST;
    inst[INST_ACC]                    = r_inst_acc;
    inst[INST_P_CEN]                  = r_p_cen;
    inst[INST_P_WEN]                  = r_p_cen;
    inst[INST_P_ADDR +: ADDR_W]       = w_p_addr;
    inst[INST_X_CEN]                  = r_x_cen;
    inst[INST_X_ADDR +: ADDR_W]       = w_x_addr;
    inst[INST_OFIFO_RD:INST_LOAD]     = r_ctrl;
  end

  assign xw_mode   = r_xw;
  assign pmem_mode = 1'b0;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
